mem_bus_arbiter: RTL

- Two-master arbiter for the byte-wide memory bus between the address decoder and the slaves (SPI flash controller, SRAM with ready generator, SPI peripheral controller).
- Master 0 is aftab_core. Master 1 is a secondary bus master (DMA / boot copier).
- Grants one master at a time and routes address, data and strobes to the slave side. Routes the slave ready back to the granted master only.
- Supports a lock for multi-byte sequences, a mandatory turnaround cycle between transfers, and a slave-response timeout.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/arb_rr2.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master byte-wide memory bus arbiter.
// Holds the FSM state encoding, one-hot grant codes and the timeout read value.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_TURN
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Read data returned to a master whose transfer timed out; sliced to DATA_W.
  localparam int                    MAX_DATA_W   = 64;
  localparam logic [MAX_DATA_W-1:0] TIMEOUT_DATA = '1;

  // Timeout counter width; kept at least one bit so TIMEOUT=0 still elaborates.
  function automatic int cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way picker: round-robin against the last served master,
// or fixed priority with master 0 highest when RR_EN is 0.
module arb_rr2
  import mem_bus_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  // last_i = 1 means master 1 was served last, so master 0 wins a tie.
  always_comb begin
    pick_o = GNT_NONE;
    unique case (req_i)
      2'b01:   pick_o = GNT_M0;
      2'b10:   pick_o = GNT_M1;
      2'b11:   pick_o = (RR_EN && !last_i) ? GNT_M1 : GNT_M0;
      default: pick_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the byte-wide memory bus: grant FSM with lock,
// one-cycle turnaround between transfers and slave-response timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 8,
  parameter int          RR_EN   = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_rd,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic              bus_err
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]        req;
  logic [1:0]        pick;
  logic              arb_last;
  logic              own_m1;
  logic              own_rd;
  logic              own_wr;
  logic              own_req;
  logic              own_lock;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              busy;
  logic              timeout_hit;
  logic              xfer_done;
  logic              xfer_err;
  logic [DATA_W-1:0] rd_data;

  assign req = {m1_rd | m1_wr, m0_rd | m0_wr};

  assign own_m1    = owner_q[1];
  assign own_rd    = own_m1 ? m1_rd    : m0_rd;
  assign own_wr    = own_m1 ? m1_wr    : m0_wr;
  assign own_lock  = own_m1 ? m1_lock  : m0_lock;
  assign own_addr  = own_m1 ? m1_addr  : m0_addr;
  assign own_wdata = own_m1 ? m1_wdata : m0_wdata;
  assign own_req   = own_rd | own_wr;

  assign busy        = (state_q == ST_BUSY);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // An unlocked TURN arbitrates with the pointer already moved to the owner.
  assign arb_last = (state_q == ST_TURN) ? own_m1 : last_q;

  arb_rr2 #(
    .RR_EN (RR_EN != 0)
  ) u_pick (
    .req_i  (req),
    .last_i (arb_last),
    .pick_o (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= GNT_NONE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    xfer_done = 1'b0;
    xfer_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = ST_BUSY;
          owner_d = pick;
        end
      end

      ST_BUSY: begin
        addr_d  = own_addr;
        wdata_d = own_wdata;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!own_req) begin
          state_d = ST_TURN;
        end else if (s_ready) begin
          xfer_done = 1'b1;
          state_d   = ST_TURN;
        end else if (timeout_hit) begin
          xfer_done = 1'b1;
          xfer_err  = 1'b1;
          state_d   = ST_TURN;
        end
      end

      ST_TURN: begin
        if (own_lock) begin
          if (own_req) begin
            state_d = ST_BUSY;
          end
        end else begin
          last_d = own_m1;
          if (pick != GNT_NONE) begin
            state_d = ST_BUSY;
            owner_d = pick;
          end else begin
            state_d = ST_IDLE;
            owner_d = GNT_NONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = GNT_NONE;
      end
    endcase
  end

  // Outside BUSY the slave sees the last address/data with both strobes low.
  always_comb begin
    s_addr  = busy ? own_addr  : addr_q;
    s_wdata = busy ? own_wdata : wdata_q;
    s_wr    = busy & own_wr;
    s_rd    = busy & own_rd & ~own_wr;
    rd_data = xfer_err ? TIMEOUT_DATA[DATA_W-1:0] : s_rdata;

    m0_rdata = (busy && owner_q == GNT_M0) ? rd_data : '0;
    m1_rdata = (busy && owner_q == GNT_M1) ? rd_data : '0;
    m0_ready = xfer_done & (owner_q == GNT_M0);
    m1_ready = xfer_done & (owner_q == GNT_M1);
    bus_err  = xfer_err;
    grant    = owner_q;
  end

endmodule
